// File: rtl/xalu_mac_ise_if.sv
// Request/result bundle between the core and the xalu_mac_ise multiply-accumulate unit.
// The core drives the master side; the MAC unit is the slave.
interface xalu_mac_ise_if #(
    parameter int XLEN = 64
);
    logic [5:0]      ise_fn;
    logic [6:0]      ise_imm;
    logic [XLEN-1:0] ise_in1;
    logic [XLEN-1:0] ise_in2;
    logic [XLEN-1:0] ise_in3;
    logic            ise_val;
    logic            ise_kill;
    logic            ise_rdy;
    logic            ise_oval;
    logic [XLEN-1:0] ise_out;

    modport master (
        output ise_fn, ise_imm, ise_in1, ise_in2, ise_in3, ise_val, ise_kill,
        input  ise_rdy, ise_oval, ise_out
    );

    modport slave (
        input  ise_fn, ise_imm, ise_in1, ise_in2, ise_in3, ise_val, ise_kill,
        output ise_rdy, ise_oval, ise_out
    );
endinterface

// File: rtl/xalu_mac_ise.sv
// Digit-serial rs1*rs2 + rs3 unit (maddlu/maddhu/madd52lu/madd52hu) on the custom-3 slot.
// Optional product reuse cache enabled by defining XALU_MAC_FUSE_EN.
module xalu_mac_ise #(
    parameter int         XLEN  = 64,
    parameter int         DIGIT = 16,
    parameter logic [1:0] ISE_V = 2'b11
) (
    input  logic           ise_clk,
    input  logic           ise_rst,
    xalu_mac_ise_if.slave  bus
);
    localparam int N      = XLEN / DIGIT;
    localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
    localparam int ACC_W  = 2 * XLEN;
    localparam int PART_W = XLEN + DIGIT;
    localparam int L52    = 52;
    localparam logic [XLEN-1:0] MASK52 = {{(XLEN-L52){1'b0}}, {L52{1'b1}}};

    typedef enum logic [1:0] {IDLE, MUL, FIN, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [XLEN-1:0]    a_q;
    logic [XLEN-1:0]    b_sh_q;
    logic [XLEN-1:0]    c_q;
    logic [1:0]         op_q;
    logic [ACC_W-1:0]   acc_q;
    logic [XLEN-1:0]    out_q;

    logic               rdy, accept, hit, w52_in, last_digit;
    logic [XLEN-1:0]    a_in, b_in;
    logic [PART_W-1:0]  part;
    logic [ACC_W-1:0]   acc_init;
    logic               unused_bits;

    function automatic logic [XLEN-1:0] limb_mask(input logic [XLEN-1:0] v, input logic w52);
        return w52 ? (v & MASK52) : v;
    endfunction

    function automatic logic [XLEN-1:0] form_result(input logic [ACC_W-1:0] prod,
                                                    input logic [XLEN-1:0]  addend,
                                                    input logic [1:0]       op);
        logic [ACC_W-1:0] f;
        f = prod + ACC_W'(addend);
        case (op)
            2'b00:   return f[XLEN-1:0];
            2'b01:   return f[ACC_W-1:XLEN];
            2'b10:   return XLEN'(prod[L52-1:0]) + addend;
            default: return XLEN'(prod[2*L52-1:L52]) + addend;
        endcase
    endfunction

    assign unused_bits = ^{bus.ise_fn[5:2], bus.ise_imm[6:2]};

    assign rdy        = (state_q == IDLE) || (state_q == DONE);
    assign accept     = ISE_V[1] & bus.ise_val & rdy & (bus.ise_fn[1:0] == 2'b11) & ~bus.ise_kill;
    assign w52_in     = bus.ise_imm[1];
    assign a_in       = limb_mask(bus.ise_in1, w52_in);
    assign b_in       = limb_mask(bus.ise_in2, w52_in);
    assign last_digit = (cnt_q == CNT_W'(N - 1));
    // Horner form, most significant digit first: acc = (acc << DIGIT) + a * digit.
    assign part       = PART_W'(a_q) * PART_W'(b_sh_q[XLEN-1 -: DIGIT]);

`ifdef XALU_MAC_FUSE_EN
    logic               fc_vld_q;
    logic [ACC_W-1:0]   fc_prod_q;
    logic [XLEN-1:0]    fc_a_q, fc_b_q, b_keep_q;
    logic               fc_w52_q;

    assign hit      = fc_vld_q && (fc_a_q == a_in) && (fc_b_q == b_in) && (fc_w52_q == w52_in);
    assign acc_init = hit ? fc_prod_q : '0;

    always_ff @(posedge ise_clk) begin
        if (!ise_rst) begin
            fc_vld_q <= 1'b0;
        end else if ((state_q == MUL || state_q == FIN) && bus.ise_kill) begin
            fc_vld_q <= 1'b0;
        end else if (state_q == FIN) begin
            fc_vld_q <= 1'b1;
        end
    end

    always_ff @(posedge ise_clk) begin
        if (accept) begin
            b_keep_q <= b_in;
        end
        if (state_q == FIN && !bus.ise_kill) begin
            fc_prod_q <= acc_q;
            fc_a_q    <= a_q;
            fc_b_q    <= b_keep_q;
            fc_w52_q  <= op_q[1];
        end
    end
`else
    assign hit      = 1'b0;
    assign acc_init = '0;
`endif

    always_ff @(posedge ise_clk) begin
        if (!ise_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = accept ? (hit ? FIN : MUL) : IDLE;
            MUL:        if (bus.ise_kill) state_d = IDLE;
                        else if (last_digit) state_d = FIN;
            FIN:        state_d = bus.ise_kill ? IDLE : DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ise_rdy  = rdy;
        bus.ise_oval = (state_q == DONE);
        bus.ise_out  = out_q;
    end

    always_ff @(posedge ise_clk) begin
        if (!ise_rst) begin
            cnt_q <= '0;
            out_q <= '0;
        end else begin
            if (accept) begin
                cnt_q <= '0;
            end else if (state_q == MUL) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (state_q == FIN && !bus.ise_kill) begin
                out_q <= form_result(acc_q, c_q, op_q);
            end
        end
    end

    // Operand capture and accumulation; data only, no reset.
    always_ff @(posedge ise_clk) begin
        if (accept) begin
            a_q    <= a_in;
            b_sh_q <= b_in;
            c_q    <= bus.ise_in3;
            op_q   <= bus.ise_imm[1:0];
            acc_q  <= acc_init;
        end else if (state_q == MUL) begin
            acc_q  <= (acc_q << DIGIT) + ACC_W'(part);
            b_sh_q <= b_sh_q << DIGIT;
        end
    end
endmodule

// File: tb/tb_xalu_mac_ise.sv
// Scoreboard bench for xalu_mac_ise: directed vectors push expected results and strobe cycles,
// a negedge monitor pops and compares on every ise_oval.
module tb_xalu_mac_ise;
    localparam int XLEN  = 64;
    localparam int DIGIT = 16;
    localparam int N     = XLEN / DIGIT;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] M52  = 64'h000F_FFFF_FFFF_FFFF;

    typedef struct {
        logic [63:0] val;
        int unsigned cyc;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];

    logic        mdl_vld = 1'b0;
    logic [63:0] mdl_a = '0;
    logic [63:0] mdl_b = '0;
    logic        mdl_w52 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    xalu_mac_ise_if #(.XLEN(XLEN)) bus();

    xalu_mac_ise #(.XLEN(XLEN), .DIGIT(DIGIT), .ISE_V(2'b11)) dut (
        .ise_clk (clk),
        .ise_rst (rst_n),
        .bus     (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.ise_oval === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got ise_out=0x%016h, expected no strobe", bus.ise_out);
            end else begin
                e = sb.pop_front();
                check({e.tag, "_value"}, bus.ise_out, e.val);
                check({e.tag, "_cycle"}, 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Drive one request at a negedge; optionally queue its expected result and strobe cycle.
    task automatic issue(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] c, input logic [63:0] expv, input string tag,
                         input bit want);
        logic        w52;
        logic [63:0] am, bm;
        logic        hit;
        int unsigned lat;
        w52 = op[1];
        am  = w52 ? (a & M52) : a;
        bm  = w52 ? (b & M52) : b;
        hit = 1'b0;
`ifdef XALU_MAC_FUSE_EN
        hit = mdl_vld && (mdl_a == am) && (mdl_b == bm) && (mdl_w52 == w52);
`endif
        lat = hit ? 1 : N + 1;
        check({tag, "_rdy_at_issue"}, 64'(bus.ise_rdy), 64'd1);
        bus.ise_fn  = 6'b000011;
        bus.ise_imm = {5'b0, op};
        bus.ise_in1 = a;
        bus.ise_in2 = b;
        bus.ise_in3 = c;
        bus.ise_val = 1'b1;
        if (want) begin
            sb.push_back('{val: expv, cyc: cyc + 1 + lat, tag: tag});
            mdl_vld = 1'b1;
            mdl_a   = am;
            mdl_b   = bm;
            mdl_w52 = w52;
        end
        @(posedge clk);
        #1 bus.ise_val = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d results still pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ise_fn = '0; bus.ise_imm = '0; bus.ise_in1 = '0; bus.ise_in2 = '0;
        bus.ise_in3 = '0; bus.ise_val = 1'b0; bus.ise_kill = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_rdy", 64'(bus.ise_rdy), 64'd1);
        check("reset_oval", 64'(bus.ise_oval), 64'd0);
        check("reset_out", bus.ise_out, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(2'b00, ONES, ONES, ONES, 64'h0, "maddlu_ones", 1'b1); wait_done();
        issue(2'b01, ONES, ONES, ONES, ONES, "maddhu_ones", 1'b1); wait_done();
        issue(2'b10, ONES, ONES, 64'h0, 64'h1, "madd52lu", 1'b1); wait_done();
        issue(2'b11, ONES, ONES, 64'h0, 64'h000F_FFFF_FFFF_FFFE, "madd52hu", 1'b1); wait_done();
        issue(2'b11, M52, ONES, 64'h0, 64'h000F_FFFF_FFFF_FFFE, "madd52hu_upper", 1'b1); wait_done();
        issue(2'b10, M52, ONES, 64'h0, 64'h1, "madd52lu_upper", 1'b1); wait_done();

        // Non-custom-3 request and a killed request in IDLE must both be ignored.
        bus.ise_fn = 6'b000001; bus.ise_val = 1'b1;
        @(posedge clk); #1 bus.ise_val = 1'b0;
        @(negedge clk);
        check("other_fn_rdy", 64'(bus.ise_rdy), 64'd1);
        bus.ise_fn = 6'b000011; bus.ise_val = 1'b1; bus.ise_kill = 1'b1;
        @(posedge clk); #1 bus.ise_val = 1'b0; bus.ise_kill = 1'b0;
        @(negedge clk);
        check("idle_kill_rdy", 64'(bus.ise_rdy), 64'd1);
        repeat (8) @(negedge clk);

        // Back-to-back: second request accepted in the DONE cycle.
        issue(2'b00, 64'd10, 64'd10, 64'd1, 64'h65, "b2b_first", 1'b1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.ise_oval === 1'b1) break;
        end
        check("b2b_done_oval", 64'(bus.ise_oval), 64'd1);
        check("b2b_done_rdy", 64'(bus.ise_rdy), 64'd1);
        issue(2'b00, 64'd3, 64'd5, 64'd7, 64'h16, "b2b_second", 1'b1);
        wait_done();

        // Kill on the second MUL cycle.
        issue(2'b00, 64'd7, 64'd7, 64'd7, 64'h0, "kill_op", 1'b0);
        @(negedge clk);
        @(negedge clk);
        bus.ise_kill = 1'b1;
        @(posedge clk); #1 bus.ise_kill = 1'b0;
        mdl_vld = 1'b0;
        @(negedge clk);
        check("kill_rdy", 64'(bus.ise_rdy), 64'd1);
        check("kill_out_held", bus.ise_out, 64'h16);
        repeat (8) @(negedge clk);
        check("kill_out_later", bus.ise_out, 64'h16);

        // Reset during FIN.
        issue(2'b00, 64'd3, 64'd5, 64'd7, 64'h0, "rst_op", 1'b0);
        repeat (5) @(negedge clk);
        check("fin_rdy", 64'(bus.ise_rdy), 64'd0);
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        mdl_vld = 1'b0;
        @(negedge clk);
        check("midrst_oval", 64'(bus.ise_oval), 64'd0);
        check("midrst_out", bus.ise_out, 64'd0);
        check("midrst_rdy", 64'(bus.ise_rdy), 64'd1);
        issue(2'b00, 64'd3, 64'd5, 64'd7, 64'h16, "after_reset", 1'b1); wait_done();

        // Product reuse sequence; latency expectation follows the build.
        issue(2'b00, 64'h8000_0000_0000_0000, 64'd2, 64'd1, 64'h1, "fuse_seed", 1'b1); wait_done();
        issue(2'b01, 64'h8000_0000_0000_0000, 64'd2, 64'd0, 64'h1, "fuse_hit", 1'b1); wait_done();
        issue(2'b00, 64'h8000_0000_0000_0000, 64'd3, 64'd0, 64'h8000_0000_0000_0000,
              "fuse_miss", 1'b1); wait_done();

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
